// File: rtl/sort_stream.sv
// sort_stream: Avalon-ST packet sorter.
// Buffers one packet of up to MAX_PKT_LEN words, bubble-sorts it in place
// (ascending or descending, chosen by desc_i on the SOP beat), then streams
// the sorted packet out with full backpressure. Words after the buffer is
// full are dropped and ovf_o pulses once for that packet.
//
// Ports
//   clk_i, rst_n_i                  clock, asynchronous active-low reset
//   desc_i                          0 = ascending, 1 = descending
//   snk_data_i/_startofpacket_i/_endofpacket_i/_valid_i, snk_ready_o : sink
//   src_data_o/_startofpacket_o/_endofpacket_o/_valid_o, src_ready_i : source
//   ovf_o                           one-cycle pulse on packet overflow
//
// Handshake: a beat transfers on a rising edge where valid and ready are
// both 1. The source holds data/sop/eop stable while valid=1 and ready=0,
// and never withdraws valid until the beat transfers.
module sort_stream #(
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 1024
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              desc_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              ovf_o
);

    localparam int AWIDTH = $clog2(MAX_PKT_LEN + 1);
    // Buffer index width; count needs one more value (MAX_PKT_LEN) than an index.
    localparam int IWIDTH = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
    localparam logic [AWIDTH-1:0] CNT_MAX = AWIDTH'(MAX_PKT_LEN);
    localparam logic [AWIDTH-1:0] CNT_ONE = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] CNT_TWO = AWIDTH'(2);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, UNLOAD} state_t;

    state_t              state_q;
    logic [DWIDTH-1:0]   mem_q [MAX_PKT_LEN];
    logic [AWIDTH-1:0]   count_q;
    logic [AWIDTH-1:0]   idx_q;      // lower index of the pair under compare
    logic [AWIDTH-1:0]   pass_q;     // completed bubble passes
    logic [AWIDTH-1:0]   rd_ptr_q;   // next word to present on the source
    logic                swapped_q;  // any swap so far in the current pass
    logic                desc_q;
    logic                ovf_seen_q; // overflow already flagged for this packet
    logic                snk_ready_q;
    logic [DWIDTH-1:0]   src_data_q;
    logic                src_sop_q;
    logic                src_eop_q;
    logic                src_valid_q;
    logic                ovf_q;

    logic                snk_beat;
    logic                wr_en;
    logic [IWIDTH-1:0]   wr_addr;
    logic [AWIDTH-1:0]   idx_hi;
    logic [IWIDTH-1:0]   lo_addr;
    logic [IWIDTH-1:0]   hi_addr;
    logic [DWIDTH-1:0]   lo_word;
    logic [DWIDTH-1:0]   hi_word;
    logic                do_swap;
    logic                last_pair;

    assign snk_beat = snk_valid_i & snk_ready_q;

    // SOP always lands in word 0 (start or restart); other beats append
    // only in LOAD and only while the buffer has room.
    assign wr_en   = snk_beat && ((state_q == IDLE || state_q == LOAD) && snk_startofpacket_i
                                  || (state_q == LOAD && count_q < CNT_MAX));
    assign wr_addr = snk_startofpacket_i ? '0 : count_q[IWIDTH-1:0];

    assign idx_hi  = idx_q + CNT_ONE;
    assign lo_addr = idx_q[IWIDTH-1:0];
    assign hi_addr = idx_hi[IWIDTH-1:0];
    assign lo_word = mem_q[lo_addr];
    assign hi_word = mem_q[hi_addr];

    // Equal words never swap, which keeps the sort stable in both directions.
    assign do_swap   = (state_q == SORT) && (count_q > CNT_ONE) && (lo_word != hi_word)
                       && ((lo_word > hi_word) ^ desc_q);
    assign last_pair = (idx_q == count_q - CNT_TWO);

    // Buffer: loaded from the sink, permuted in place during SORT.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= snk_data_i;
        end
        if (do_swap) begin
            mem_q[lo_addr] <= hi_word;
            mem_q[hi_addr] <= lo_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            rd_ptr_q    <= '0;
            swapped_q   <= 1'b0;
            desc_q      <= 1'b0;
            ovf_seen_q  <= 1'b0;
            snk_ready_q <= 1'b0;
            src_data_q  <= '0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    snk_ready_q <= 1'b1;
                    if (snk_beat && snk_startofpacket_i) begin
                        count_q    <= CNT_ONE;
                        desc_q     <= desc_i;
                        ovf_seen_q <= 1'b0;
                        if (snk_endofpacket_i) begin
                            state_q     <= SORT;
                            snk_ready_q <= 1'b0;
                            idx_q       <= '0;
                            pass_q      <= '0;
                            swapped_q   <= 1'b0;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    snk_ready_q <= 1'b1;
                    if (snk_beat) begin
                        if (snk_startofpacket_i) begin
                            count_q    <= CNT_ONE;
                            desc_q     <= desc_i;
                            ovf_seen_q <= 1'b0;
                        end else if (count_q < CNT_MAX) begin
                            count_q <= count_q + CNT_ONE;
                        end else if (!ovf_seen_q) begin
                            ovf_q      <= 1'b1;
                            ovf_seen_q <= 1'b1;
                        end
                        if (snk_endofpacket_i) begin
                            state_q     <= SORT;
                            snk_ready_q <= 1'b0;
                            idx_q       <= '0;
                            pass_q      <= '0;
                            swapped_q   <= 1'b0;
                        end
                    end
                end
                SORT: begin
                    if (count_q <= CNT_ONE) begin
                        state_q     <= UNLOAD;
                        rd_ptr_q    <= '0;
                        src_valid_q <= 1'b0;
                    end else if (last_pair) begin
                        // A clean pass means sorted; count-1 passes always suffice.
                        if (!(swapped_q || do_swap) || (pass_q == count_q - CNT_TWO)) begin
                            state_q     <= UNLOAD;
                            rd_ptr_q    <= '0;
                            src_valid_q <= 1'b0;
                        end else begin
                            idx_q     <= '0;
                            swapped_q <= 1'b0;
                            pass_q    <= pass_q + CNT_ONE;
                        end
                    end else begin
                        idx_q     <= idx_hi;
                        swapped_q <= swapped_q | do_swap;
                    end
                end
                UNLOAD: begin
                    // Output register refills whenever it is empty or being consumed.
                    if (!src_valid_q || src_ready_i) begin
                        if (src_valid_q && src_eop_q) begin
                            src_valid_q <= 1'b0;
                            src_sop_q   <= 1'b0;
                            src_eop_q   <= 1'b0;
                            state_q     <= IDLE;
                            snk_ready_q <= 1'b1;
                        end else if (rd_ptr_q < count_q) begin
                            src_data_q  <= mem_q[rd_ptr_q[IWIDTH-1:0]];
                            src_sop_q   <= (rd_ptr_q == '0);
                            src_eop_q   <= (rd_ptr_q == count_q - CNT_ONE);
                            src_valid_q <= 1'b1;
                            rd_ptr_q    <= rd_ptr_q + CNT_ONE;
                        end else begin
                            src_valid_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign snk_ready_o         = snk_ready_q;
    assign src_data_o          = src_data_q;
    assign src_startofpacket_o = src_sop_q;
    assign src_endofpacket_o   = src_eop_q;
    assign src_valid_o         = src_valid_q;
    assign ovf_o               = ovf_q;

endmodule

// File: tb/tb_sort_stream.sv
// Bench for sort_stream with a 16-word buffer.
module tb_sort_stream;

    localparam int DW  = 8;
    localparam int MAX = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          desc = 1'b0;
    logic [DW-1:0] snk_data = '0;
    logic          snk_sop = 1'b0;
    logic          snk_eop = 1'b0;
    logic          snk_valid = 1'b0;
    logic          snk_ready;
    logic [DW-1:0] src_data;
    logic          src_sop;
    logic          src_eop;
    logic          src_valid;
    logic          src_ready = 1'b1;
    logic          ovf;

    sort_stream #(.DWIDTH(DW), .MAX_PKT_LEN(MAX)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .desc_i              (desc),
        .snk_data_i          (snk_data),
        .snk_startofpacket_i (snk_sop),
        .snk_endofpacket_i   (snk_eop),
        .snk_valid_i         (snk_valid),
        .snk_ready_o         (snk_ready),
        .src_data_o          (src_data),
        .src_startofpacket_o (src_sop),
        .src_endofpacket_o   (src_eop),
        .src_valid_o         (src_valid),
        .src_ready_i         (src_ready),
        .ovf_o               (ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ovf_cnt = 0;
    int ready_mode = 0;  // 0: always ready, 1: toggle, 2: random

    // Expected output beats, {sop, eop, data}.
    logic [DW+1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer ready, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       src_ready = 1'b1;
                1:       src_ready = ~src_ready;
                default: src_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [DW+1:0] prev_beat = '0;
    logic          prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (src_valid) begin
                if (prev_stall)
                    check("stall_hold", 32'({src_sop, src_eop, src_data}), 32'(prev_beat));
                if (src_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %0h expected none",
                                 {src_sop, src_eop, src_data});
                    end else begin
                        check("out_beat", 32'({src_sop, src_eop, src_data}), 32'(exp_q.pop_front()));
                    end
                end
            end
            prev_stall = src_valid && !src_ready;
            prev_beat  = {src_sop, src_eop, src_data};
            if (ovf) ovf_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                             input bit gaps);
        logic acc;
        int   budget;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        snk_valid = 1'b1;
        snk_data  = d;
        snk_sop   = sop;
        snk_eop   = eop;
        budget    = 0;
        forever begin
            @(negedge clk);
            acc = snk_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            budget++;
            if (budget > 5000) begin
                n_tests++;
                n_fail++;
                $display("FAIL snk_ready_timeout: got 0 expected 1");
                break;
            end
        end
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 5000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_expected(input logic [DW-1:0] w[$]);
        for (int i = 0; i < w.size(); i++)
            exp_q.push_back({(i == 0), (i == w.size() - 1), w[i]});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int           n;        // words sent
        logic         dsc;
        logic [159:0] w;        // word i at w[8*(n-1-i) +: 8]
        int           n_exp;
        logic [159:0] e;        // expected word i at e[8*(n_exp-1-i) +: 8]
        int           ovf_exp;
        int           rmode;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vec [NVEC];

    initial begin
        logic [DW-1:0] rw[$];
        logic [DW-1:0] sw[$];
        int ovf0;

        vec[0] = '{3, 1'b0, 160'({8'd9, 8'd1, 8'd5}), 3, 160'({8'd1, 8'd5, 8'd9}), 0, 0};
        vec[1] = '{4, 1'b1, 160'({8'd3, 8'd7, 8'd7, 8'd0}), 4, 160'({8'd7, 8'd7, 8'd3, 8'd0}), 0, 1};
        vec[2] = '{1, 1'b0, 160'(8'hA5), 1, 160'(8'hA5), 0, 0};
        vec[3] = '{3, 1'b1, 160'({8'd4, 8'd4, 8'd4}), 3, 160'({8'd4, 8'd4, 8'd4}), 0, 2};
        vec[4] = '{8, 1'b1, 160'({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}),
                   8, 160'({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}), 0, 2};
        vec[5] = '{20, 1'b0,
                   {8'd3, 8'd10, 8'd17, 8'd24, 8'd31, 8'd6, 8'd13, 8'd20, 8'd27, 8'd2,
                    8'd9, 8'd16, 8'd23, 8'd30, 8'd5, 8'd12, 8'd19, 8'd26, 8'd1, 8'd8},
                   16, 160'({8'd2, 8'd3, 8'd5, 8'd6, 8'd9, 8'd10, 8'd12, 8'd13,
                             8'd16, 8'd17, 8'd20, 8'd23, 8'd24, 8'd27, 8'd30, 8'd31}), 1, 0};
        vec[6] = '{5, 1'b0, 160'({8'd255, 8'd0, 8'd128, 8'd0, 8'd255}),
                   5, 160'({8'd0, 8'd0, 8'd128, 8'd255, 8'd255}), 0, 1};
        vec[7] = '{16, 1'b1,
                   160'({8'd3, 8'd10, 8'd17, 8'd24, 8'd31, 8'd6, 8'd13, 8'd20, 8'd27, 8'd2,
                         8'd9, 8'd16, 8'd23, 8'd30, 8'd5, 8'd12}),
                   16, 160'({8'd31, 8'd30, 8'd27, 8'd24, 8'd23, 8'd20, 8'd17, 8'd16,
                             8'd13, 8'd12, 8'd10, 8'd9, 8'd6, 8'd5, 8'd3, 8'd2}), 0, 2};

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({src_data, src_sop, src_eop, src_valid, snk_ready, ovf}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready_after_reset", 32'(snk_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a packet: 5 beats, no EOP.
        desc = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(8'(40 + i), (i == 0), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midload_reset_outputs",
              32'({src_data, src_sop, src_eop, src_valid, snk_ready, ovf}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors.
        for (int t = 0; t < NVEC; t++) begin
            ready_mode = vec[t].rmode;
            desc       = vec[t].dsc;
            ovf0       = ovf_cnt;
            for (int i = 0; i < vec[t].n_exp; i++)
                exp_q.push_back({(i == 0), (i == vec[t].n_exp - 1),
                                 vec[t].e[8*(vec[t].n_exp-1-i) +: 8]});
            for (int i = 0; i < vec[t].n; i++)
                send_beat(vec[t].w[8*(vec[t].n-1-i) +: 8], (i == 0), (i == vec[t].n - 1),
                          (t % 2) == 1);
            wait_drain();
            check($sformatf("ovf_count_v%0d", t), 32'(ovf_cnt - ovf0), 32'(vec[t].ovf_exp));
        end

        // Ten random words, ascending, random valid gaps, consumer always ready.
        ready_mode = 0;
        desc = 1'b0;
        rw.delete();
        for (int i = 0; i < 10; i++) rw.push_back(8'($urandom_range(0, 255)));
        sw = rw;
        sw.sort();
        push_expected(sw);
        ovf0 = ovf_cnt;
        for (int i = 0; i < 10; i++) send_beat(rw[i], (i == 0), (i == 9), 1'b1);
        wait_drain();
        check("ovf_count_random", 32'(ovf_cnt - ovf0), 32'd0);

        // Restart: 4 words of a descending packet, then a new ascending 6-word packet.
        ready_mode = 2;
        desc = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(8'(200 + i), (i == 0), 1'b0, 1'b0);
        desc = 1'b0;
        rw = '{8'd50, 8'd20, 8'd60, 8'd10, 8'd40, 8'd30};
        sw = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        push_expected(sw);
        for (int i = 0; i < 6; i++) send_beat(rw[i], (i == 0), (i == 5), 1'b0);
        wait_drain();

        // Beats without SOP in IDLE are dropped; the following packet is unaffected.
        ready_mode = 0;
        desc = 1'b1;
        send_beat(8'd99, 1'b0, 1'b0, 1'b0);
        send_beat(8'd98, 1'b0, 1'b1, 1'b0);
        sw = '{8'd3, 8'd2};
        push_expected(sw);
        send_beat(8'd2, 1'b1, 1'b0, 1'b0);
        send_beat(8'd3, 1'b0, 1'b1, 1'b0);
        wait_drain();
        @(negedge clk);
        check("idle_after_packet", 32'({src_valid, snk_ready}), 32'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
